// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// long-latency results queue in a small FIFO and drain into idle slots.
module rf_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_wreg,
  input  logic [31:0]   pipe_wdata,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_wreg,
  input  logic [31:0]   lu_wdata,
  input  logic [4:0]    Read_register1,
  input  logic [4:0]    Read_register2,
  output logic          pend_hit1,
  output logic          pend_hit2,
  output logic          RegWrite,
  output logic [4:0]    Write_register,
  output logic [31:0]   Write_data,
  output logic [AW:0]   fifo_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]       ent_reg  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic slot_busy;
  logic push;
  logic pop;

  assign lu_ready  = (fifo_count != FULL);
  assign slot_busy = pipe_we && (pipe_wreg != '0);
  // Writes to $zero are accepted off the handshake but never stored.
  assign push      = lu_valid && lu_ready && (lu_wreg != '0) && !reset;
  assign pop       = !slot_busy && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ent_valid      <= '0;
    end else begin
      if (slot_busy) begin
        RegWrite       <= 1'b1;
        Write_register <= pipe_wreg;
        Write_data     <= pipe_wdata;
      end else if (pop) begin
        RegWrite       <= 1'b1;
        Write_register <= ent_reg[rd_ptr];
        Write_data     <= ent_data[rd_ptr];
      end else begin
        RegWrite <= 1'b0;
      end

      // Push and pop never share an index: equal pointers mean empty or full.
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + AW'(1);
      end

      if (push && !pop)
        fifo_count <= fifo_count + (AW+1)'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr]  <= lu_wreg;
      ent_data[wr_ptr] <= lu_wdata;
    end
  end

  always_comb begin
    pend_hit1 = RegWrite && (Write_register == Read_register1);
    pend_hit2 = RegWrite && (Write_register == Read_register2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_reg[i] == Read_register1)) pend_hit1 = 1'b1;
      if (ent_valid[i] && (ent_reg[i] == Read_register2)) pend_hit2 = 1'b1;
    end
    if (Read_register1 == '0) pend_hit1 = 1'b0;
    if (Read_register2 == '0) pend_hit2 = 1'b0;
  end

endmodule
